// File: rtl/writeback_dest_pipe.sv
// Write-back destination pipeline: selects the destination register of each
// instruction, carries it through DEPTH valid/ready stages and exposes the
// in-flight writes as a busy bitmap with two source-register hazard queries.
module writeback_dest_pipe #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LINK_REG = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      rt,
    input  logic [ADDR_W-1:0]      rd,
    input  logic [1:0]             reg_dst,
    input  logic                   reg_write,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      write_register,
    output logic                   write_enable,
    output logic [2**ADDR_W-1:0]   busy,
    input  logic [ADDR_W-1:0]      src_a,
    input  logic [ADDR_W-1:0]      src_b,
    output logic                   hazard_a,
    output logic                   hazard_b
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DEPTH-1:0]  validQ, validD;
    logic [DEPTH-1:0]  wenQ, wenD;
    logic [ADDR_W-1:0] destQ [DEPTH];
    logic [ADDR_W-1:0] destD [DEPTH];

    // take[i]: stage i can load this edge; take[DEPTH] is the consumer.
    logic [DEPTH:0]    take;
    logic [ADDR_W-1:0] selDest;
    logic              selWen;
    logic              accept;

    // Stage i can load when empty or when its own entry moves on downstream.
    always_comb begin
        take[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            take[i] = !validQ[i] || take[i+1];
        end
    end

    // Destination select; a write to register 0 is treated as no write.
    always_comb begin
        selDest = '0;
        unique case (reg_dst)
            2'b00:   selDest = rt;
            2'b01:   selDest = rd;
            2'b10:   selDest = ADDR_W'(LINK_REG);
            default: selDest = '0;
        endcase
        selWen = reg_write && (reg_dst != 2'b11) && (selDest != '0);
    end

    assign in_ready = take[0] && !flush;
    assign accept   = in_valid && in_ready;

    // Next-state: flush clears every valid bit; otherwise shift into free stages.
    always_comb begin
        validD = validQ;
        wenD   = wenQ;
        for (int i = 0; i < int'(DEPTH); i++) begin
            destD[i] = destQ[i];
        end
        if (flush) begin
            validD = '0;
        end else begin
            if (take[0]) begin
                validD[0] = accept;
                if (accept) begin
                    destD[0] = selDest;
                    wenD[0]  = selWen;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (take[i]) begin
                    validD[i] = validQ[i-1];
                    if (validQ[i-1]) begin
                        destD[i] = destQ[i-1];
                        wenD[i]  = wenQ[i-1];
                    end
                end
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ <= '0;
            wenQ   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                destQ[i] <= '0;
            end
        end else begin
            validQ <= validD;
            wenQ   <= wenD;
            for (int i = 0; i < int'(DEPTH); i++) begin
                destQ[i] <= destD[i];
            end
        end
    end

    // Busy bitmap: OR of one-hot destinations of all valid, enabled stages.
    always_comb begin
        busy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (validQ[i] && wenQ[i]) begin
                busy[destQ[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    assign out_valid      = validQ[DEPTH-1];
    assign write_register = destQ[DEPTH-1];
    assign write_enable   = validQ[DEPTH-1] && wenQ[DEPTH-1];
    assign hazard_a       = busy[src_a];
    assign hazard_b       = busy[src_b];

    // NumRegs documents the bitmap size; it must match the busy port width.
    if ($bits(busy) != NumRegs) begin : gBadWidth
        $error("busy width mismatch");
    end

endmodule

// File: tb/tb_writeback_dest_pipe.sv
// Bench for writeback_dest_pipe: directed steps followed by random traffic,
// checked against a queue model in which entries slide towards the output.
module tb_writeback_dest_pipe;

    localparam int unsigned AW = 5;
    localparam int          D  = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready;
    logic [AW-1:0] rt, rd, write_register, src_a, src_b;
    logic [1:0]    reg_dst;
    logic          reg_write, out_valid, out_ready, write_enable;
    logic [31:0]   busy;
    logic          hazard_a, hazard_b;

    int checks = 0;
    int errors = 0;

    writeback_dest_pipe #(.ADDR_W(AW), .DEPTH(D), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .rt(rt), .rd(rd), .reg_dst(reg_dst),
        .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
        .write_register(write_register), .write_enable(write_enable),
        .busy(busy), .src_a(src_a), .src_b(src_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b)
    );

    always #5 clk = ~clk;

    // Model: in-order list of entries, each with its stage position.
    typedef struct {
        logic [AW-1:0] dest;
        bit            wen;
        int            pos;
    } ent_t;
    typedef ent_t entQ_t[$];

    entQ_t q;

    // One edge: pop the head if consumed, then each entry slides forward as
    // far as the (already moved) entry ahead of it allows.
    function automatic entQ_t moved(entQ_t src, bit ordy);
        entQ_t t;
        int lim;
        t = src;
        if (t.size() > 0 && t[0].pos == D - 1 && ordy) void'(t.pop_front());
        lim = D - 1;
        foreach (t[k]) begin
            t[k].pos = (t[k].pos + 1 < lim) ? t[k].pos + 1 : lim;
            lim = t[k].pos - 1;
        end
        return t;
    endfunction

    function automatic logic [31:0] busyOf(entQ_t src);
        logic [31:0] b;
        b = '0;
        foreach (src[k]) if (src[k].wen) b[src[k].dest] = 1'b1;
        return b;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic cyc(bit iv, logic [AW-1:0] irt, logic [AW-1:0] ird, logic [1:0] dst,
                       bit rw, bit ordy, bit fl, logic [AW-1:0] sa, logic [AW-1:0] sb);
        entQ_t nq;
        bit expRdy, expOv;
        logic [31:0] b;
        logic [AW-1:0] d;
        bit w;
        in_valid = iv; rt = irt; rd = ird; reg_dst = dst; reg_write = rw;
        out_ready = ordy; flush = fl; src_a = sa; src_b = sb;
        @(negedge clk);
        nq = moved(q, ordy);
        expRdy = !fl;
        foreach (nq[k]) if (nq[k].pos == 0) expRdy = 1'b0;
        expOv = q.size() > 0 && q[0].pos == D - 1;
        b = busyOf(q);
        check("in_ready", 64'(in_ready), 64'(expRdy));
        check("out_valid", 64'(out_valid), 64'(expOv));
        if (expOv) check("write_register", 64'(write_register), 64'(q[0].dest));
        check("write_enable", 64'(write_enable), 64'(expOv && q[0].wen));
        check("busy", 64'(busy), 64'(b));
        check("hazard_a", 64'(hazard_a), 64'(b[sa]));
        check("hazard_b", 64'(hazard_b), 64'(b[sb]));
        case (dst)
            2'b00:   d = irt;
            2'b01:   d = ird;
            2'b10:   d = 5'd31;
            default: d = '0;
        endcase
        w = rw && dst != 2'b11 && d != 0;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            q = nq;
            if (iv && expRdy) q.push_back('{dest: d, wen: w, pos: 0});
        end
        #1;
    endtask

    task automatic idle(bit ordy);
        cyc(1'b0, '0, '0, 2'b00, 1'b0, ordy, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic resetChecks(string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_write_register"}, 64'(write_register), 64'd0);
        check({tag, "_write_enable"}, 64'(write_enable), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; rt = '0; rd = '0;
        reg_dst = 2'b00; reg_write = 1'b0; out_ready = 1'b0; src_a = '0; src_b = '0;
        #12;
        resetChecks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First transaction: rd=9 selected, then consumed.
        cyc(1'b1, 5'd8, 5'd9, 2'b01, 1'b1, 1'b1, 1'b0, 5'd9, 5'd8);
        idle(1'b1);
        cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd9, 5'd0);
        idle(1'b1);

        // Selection modes, including rd=0 which must not set busy.
        cyc(1'b1, 5'd8, 5'd9, 2'b00, 1'b1, 1'b1, 1'b0, 5'd8, 5'd31);
        cyc(1'b1, 5'd8, 5'd9, 2'b10, 1'b1, 1'b1, 1'b0, 5'd8, 5'd31);
        cyc(1'b1, 5'd8, 5'd9, 2'b11, 1'b1, 1'b1, 1'b0, 5'd8, 5'd31);
        cyc(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 1'b1, 1'b0, 5'd31, 5'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Back-to-back stream of six.
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 5'(i + 1), 5'(i + 10), 2'(i % 2), 1'b1, 1'b1, 1'b0, 5'(i), 5'(i + 9));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Stall: fill both stages, then drain.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'(i + 3), 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Duplicate destination 5 in flight.
        cyc(1'b1, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
        cyc(1'b1, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0);

        // Flush with two entries in flight and an input presented.
        cyc(1'b1, 5'd6, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7);
        cyc(1'b1, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7);
        cyc(1'b1, 5'd12, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd12, 5'd7);
        idle(1'b1);

        // Asynchronous reset mid-stream.
        cyc(1'b1, 5'd13, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd13, 5'd0);
        cyc(1'b1, 5'd14, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd13, 5'd14);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        resetChecks("async_reset");
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_dest_pipe.md
# writeback_dest_pipe

Parametrised successor to the single-cycle write-address select in the datapath. Selects the destination register per instruction (rt, rd, link register, or none), carries it through a configurable number of pipeline stages with valid/ready handshaking, and presents it to the register file write port. The in-flight destinations are also exposed as a busy bitmap with two read-port hazard queries, so the issue logic can stall on RAW dependencies.

## Interface
- ADDR_W, 5, register address width; register file has 2**ADDR_W entries
- DEPTH, 2, number of pipeline stages from accept to write-back output (legal 1..8)
- LINK_REG, 31, register selected when reg_dst = 2'b10 (jal-style link)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous pipeline flush; discards all in-flight entries
- in_valid  input  1  instruction destination info valid
- in_ready  output  1  stage 0 can accept this cycle
- rt  input  ADDR_W  rt field
- rd  input  ADDR_W  rd field
- reg_dst  input  2  00 rt, 01 rd, 10 LINK_REG, 11 no destination
- reg_write  input  1  instruction writes the register file
- out_valid  output  1  final stage holds an entry
- out_ready  input  1  write-back consumer accepts this cycle
- write_register  output  ADDR_W  destination of the final-stage entry
- write_enable  output  1  final-stage entry performs a register write
- busy  output  2**ADDR_W  bit i set while any valid stage holds an enabled write to register i
- src_a, src_b  input  ADDR_W  issue-stage source registers
- hazard_a, hazard_b  output  1  busy[src_a], busy[src_b]

## Operation
- Destination selection at accept: dest = rt / rd / LINK_REG per reg_dst. The write-enable bit is set only if reg_write = 1, reg_dst != 11, and dest != 0.
- Entries with write-enable = 0 still flow through the pipeline (they occupy slots and produce out_valid). They write nothing and never set busy.
- Each stage i holds {valid, dest, wen}. Stage i advances into i+1 when i+1 is empty or is itself advancing. The final stage empties when out_valid && out_ready.
- in_ready = !stage0.valid || stage0 advancing. in_ready is forced 0 while flush = 1.
- Accept occurs on an edge when in_valid && in_ready are both high.
- busy is the combinational OR over all valid stages with wen = 1 of onehot(dest). busy[0] is always 0.
- hazard_a = busy[src_a] and hazard_b = busy[src_b], both combinational. src = 0 never flags a hazard.
- write_register and write_enable reflect the final stage. write_enable is 0 whenever out_valid = 0.
- flush: at the next edge all valid bits clear and any input presented that cycle is dropped. flush has priority over accept and advance.

## Timing
- Reset values (rst_n low, asynchronous):
  - all stage valid bits = 0, dest = 0, wen = 0
  - out_valid = 0, write_register = 0, write_enable = 0, busy = 0
  - in_ready = 1 (once rst_n is high and flush = 0)
- Reset mid-operation discards all entries immediately, without waiting for an edge.
- Latency: an entry accepted at edge E0 appears at the output (out_valid = 1) after edge E(DEPTH-1). With DEPTH = 1 it appears right after E0.
- Throughput: one entry per cycle when out_ready is held at 1.
- Stall: while out_ready = 0, entries compress into empty stages. in_ready falls only once all DEPTH stages are valid. Output signals hold stable until the entry is consumed.
- Simultaneous accept and output consume in one edge are legal; occupancy is unchanged.
- busy updates in the same cycle an entry enters stage 0 (visible after the accept edge). A bit clears in the cycle after the consuming edge, unless another stage still holds the same dest.
- Duplicate destinations in flight: busy stays set until the last matching entry leaves.

## Test plan
- Reset, then DEPTH=2: accept {rt=8, rd=9, reg_dst=01, reg_write=1} at E0.
  - busy[9] = 1 after E0.
  - out_valid = 1 with write_register = 9, write_enable = 1 after E1.
  - With out_ready = 1, busy = 0 after E2.
- Selection modes: reg_dst=00 gives 8, 10 gives 31 (wen 1), 11 gives wen 0. rd=0 with reg_dst=01 gives wen 0 and busy unchanged.
- Back-to-back stream of 6 entries with out_ready = 1: one output per cycle, in order, and in_ready never drops.
- Hold out_ready = 0 with in_valid = 1: in_ready drops after 2 accepts. Outputs stay stable. Releasing out_ready drains both entries in order.
- Two in-flight writes to reg 5 with src_a = 5: hazard_a stays 1 until the second entry is consumed. src_b = 0 keeps hazard_b = 0.
- flush with 2 entries in flight and in_valid = 1: the next edge gives out_valid = 0 and busy = 0, and the input is dropped. rst_n pulsed low mid-stream clears all outputs asynchronously.
